// File: rtl/msg_block_mgr.sv
// Packs a byte stream into 16-word message blocks for a hash core and
// serialises the returned digest back out as bytes, LSB byte first.
module msg_block_mgr #(
    parameter int              W         = 32,
    parameter int              OUT_BYTES = W,
    parameter bit              XOR_EN    = 1'b1,
    parameter logic [8*W-1:0]  XOR_VAL   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        data_in,
    input  logic              dv_in,
    output logic              drdy_out,
    input  logic              finish,
    output logic              msg_strobe,
    input  logic              msg_ack,
    output logic [16*W-1:0]   m_out,
    output logic [2*W-1:0]    t_out,
    output logic              f_out,
    input  logic [8*W-1:0]    h_in,
    input  logic              h_rdy,
    output logic [7:0]        data_out,
    output logic              dv_out,
    input  logic              dout_rdy,
    output logic              data_end,
    output logic              busy
);
    localparam int BB = 2 * W;
    localparam int CW = $clog2(BB) + 1;
    localparam int OW = $clog2(W) + 1;

    localparam logic [CW-1:0]   CNT_FULL = CW'(BB);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [2*W-1:0]  T_ONE    = (2*W)'(1);
    localparam logic [OW-1:0]   OC_INIT  = OW'(OUT_BYTES);
    localparam logic [OW-1:0]   OC_ONE   = OW'(1);
    localparam logic [8*W-1:0]  H_MASK   = XOR_EN ? XOR_VAL : '0;

    typedef enum logic [1:0] {S_FILL, S_WAIT, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [16*W-1:0]   m_q, m_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*W-1:0]    t_q, t_d;
    logic              f_q, f_d;
    logic              msg_strobe_q, msg_strobe_d;
    logic [8*W-1:0]    h_q, h_d;
    logic [OW-1:0]     out_cnt_q, out_cnt_d;

    logic              full;

    assign full = (cnt_q == CNT_FULL);

    always_comb begin
        state_d      = state_q;
        m_d          = m_q;
        cnt_d        = cnt_q;
        t_d          = t_q;
        f_d          = f_q;
        msg_strobe_d = 1'b0;
        if (start) begin
            state_d = S_FILL;
            m_d     = '0;
            cnt_d   = '0;
            t_d     = '0;
            f_d     = 1'b0;
        end else begin
            case (state_q)
                S_FILL: begin
                    // A byte with room wins over finish; finish is seen next cycle.
                    if (dv_in && !full) begin
                        for (int k = 0; k < BB; k++) begin
                            if (cnt_q == CW'(k)) m_d[8*k +: 8] = data_in;
                        end
                        cnt_d = cnt_q + CNT_ONE;
                        t_d   = t_q + T_ONE;
                    end else if (dv_in && full) begin
                        f_d          = 1'b0;
                        msg_strobe_d = 1'b1;
                        state_d      = S_WAIT;
                    end else if (finish) begin
                        f_d          = 1'b1;
                        msg_strobe_d = 1'b1;
                        state_d      = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (msg_ack) begin
                        if (f_q) begin
                            state_d = S_DONE;
                        end else begin
                            m_d     = '0;
                            cnt_d   = '0;
                            state_d = S_FILL;
                        end
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_FILL;
            endcase
        end
    end

    always_comb begin
        h_d       = h_q;
        out_cnt_d = out_cnt_q;
        if (h_rdy) begin
            h_d       = h_in ^ H_MASK;
            out_cnt_d = OC_INIT;
        end else if ((out_cnt_q != '0) && dout_rdy) begin
            h_d       = h_q >> 8;
            out_cnt_d = out_cnt_q - OC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FILL;
            m_q          <= '0;
            cnt_q        <= '0;
            t_q          <= '0;
            f_q          <= 1'b0;
            msg_strobe_q <= 1'b0;
            h_q          <= '0;
            out_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            m_q          <= m_d;
            cnt_q        <= cnt_d;
            t_q          <= t_d;
            f_q          <= f_d;
            msg_strobe_q <= msg_strobe_d;
            h_q          <= h_d;
            out_cnt_q    <= out_cnt_d;
        end
    end

    assign drdy_out   = (state_q == S_FILL) && !full;
    assign msg_strobe = msg_strobe_q;
    assign m_out      = m_q;
    assign t_out      = t_q;
    assign f_out      = f_q;
    assign data_out   = h_q[7:0];
    assign dv_out     = (out_cnt_q != '0);
    assign data_end   = (out_cnt_q == OC_ONE);
    assign busy       = (state_q != S_FILL) || (cnt_q != '0);
endmodule
